led_sequencer: RTL and testbench

Programmable sequencer for the three active-low board LEDs, timed from the 2 MHz on-chip oscillator clock. A byte-wide command stream (valid/ready, normally fed by the UART receiver on `fpga_rx`) loads a small program of (pattern, duration) steps. The block plays the program once or in a loop, taking over the free-running toggle counter's role as the single driver of `gpio`.

---
 rtl/led_sequencer.sv | 164 ++++++++++++++++
 tb/tb_led_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// Programmable LED sequencer: a byte command stream loads (pattern, duration) steps
// that are replayed once or in a loop on the active-low gpio LEDs.
module led_sequencer #(
    parameter int TICK_DIV = 200_000,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [2:0]               gpio,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     overflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [7:0] CMD_CLEAR = 8'h80;
    localparam logic [7:0] CMD_LOOP  = 8'h81;
    localparam logic [7:0] CMD_ONCE  = 8'h82;
    localparam logic [7:0] CMD_STOP  = 8'h83;

    // busy is the decoded state (PLAY) and doubles as the FSM observation point.
    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            loop_q, loop_d;
    logic            cmd_vld_q, cmd_vld_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [6:0]      prog_q [DEPTH];
    logic [6:0]      prog_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4:0]      tick_q, tick_d;

    logic [6:0]      cur_step;
    logic [4:0]      cur_dur;
    logic            last_presc;

    assign cur_step   = prog_q[idx_q];
    assign cur_dur    = (cur_step[3:0] == 4'd0) ? 5'd16 : {1'b0, cur_step[3:0]};
    assign last_presc = (presc_q == PW'(TICK_DIV - 1));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            loop_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            cmd_q     <= 8'h00;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            idx_q     <= '0;
            presc_q   <= '0;
            tick_q    <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                prog_q[i] <= 7'd0;
            end
        end else begin
            state_q   <= state_d;
            loop_q    <= loop_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            idx_q     <= idx_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            for (int i = 0; i < DEPTH; i++) begin
                prog_q[i] <= prog_d[i];
            end
        end
    end

    // Next-state: playback timing first, then the decoded command overrides it.
    always_comb begin
        state_d   = state_q;
        loop_d    = loop_q;
        cmd_vld_d = cmd_valid && cmd_ready;
        cmd_d     = (cmd_valid && cmd_ready) ? cmd_data : cmd_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        presc_d   = presc_q;
        tick_d    = tick_q;
        for (int i = 0; i < DEPTH; i++) begin
            prog_d[i] = prog_q[i];
        end

        if (state_q == S_PLAY) begin
            if (last_presc) begin
                presc_d = '0;
                if (tick_q == cur_dur) begin
                    tick_d = 5'd1;
                    if ({1'b0, idx_q} + CW'(1) == count_q) begin
                        idx_d = '0;
                        if (!loop_q) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    tick_d = tick_q + 5'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (cmd_vld_q) begin
            if (!cmd_q[7]) begin
                if (state_q == S_IDLE && count_q < CW'(DEPTH)) begin
                    prog_d[count_q[IW-1:0]] = cmd_q[6:0];
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                case (cmd_q)
                    CMD_CLEAR: begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                    CMD_LOOP, CMD_ONCE: begin
                        if (count_q != '0) begin
                            state_d = S_PLAY;
                            loop_d  = (cmd_q == CMD_LOOP);
                            idx_d   = '0;
                            presc_d = '0;
                            tick_d  = 5'd1;
                        end
                    end
                    CMD_STOP: state_d = S_IDLE;
                    default: ;
                endcase
            end
        end

        if (state_d == S_IDLE) begin
            idx_d   = '0;
            presc_d = '0;
            tick_d  = 5'd0;
        end
    end

    // Outputs: valid/ready handshake transfers a byte on any edge where both are high;
    // ready drops for the single cycle in which that byte is being decoded.
    always_comb begin
        cmd_ready = ~cmd_vld_q;
        busy      = (state_q == S_PLAY);
        gpio      = busy ? ~cur_step[6:4] : 3'b111;
        step_idx  = busy ? idx_q : '0;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with TICK_DIV = 4, DEPTH = 4; per-cycle expectations are
// queued as {busy, step_idx, gpio} and popped against the DUT each cycle.
module tb_led_sequencer;

    logic       clk;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] gpio;
    logic       busy;
    logic [1:0] step_idx;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] exp_q [$];

    led_sequencer #(.TICK_DIV(4), .DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .gpio      (gpio),
        .busy      (busy),
        .step_idx  (step_idx),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns just after the accepting edge T (cmd_valid already dropped).
    task automatic send_cmd(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (w >= 10) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    function automatic logic [5:0] obs(input logic b, input logic [1:0] i, input logic [2:0] pat);
        return b ? {1'b1, i, ~pat} : {1'b0, 2'd0, 3'b111};
    endfunction

    task automatic test_reset();
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        #12;
        n_cmp++;
        if ({busy, step_idx, gpio} !== 6'b0_00_111) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required %b", {busy, step_idx, gpio}, 6'b0_00_111);
        end
        n_cmp++;
        if ({cmd_ready, overflow} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_ready_ovf: got %b required 10", {cmd_ready, overflow});
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_ready_toggle();
        logic [5:0] e;
        @(negedge clk);
        cmd_data  = 8'h84;
        cmd_valid = 1'b1;
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({5'd0, cmd_ready} !== e) begin
                n_err++;
                $display("FAIL ready_toggle[%0d]: got %b required %b", i, cmd_ready, e[0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_once();
        logic [5:0] e;
        send_cmd(8'h12);
        send_cmd(8'h51);
        send_cmd(8'h82);
        for (int i = 1; i <= 13; i++) begin
            if (i <= 8)       exp_q.push_back(obs(1'b1, 2'd0, 3'b001));
            else if (i <= 12) exp_q.push_back(obs(1'b1, 2'd1, 3'b101));
            else              exp_q.push_back(obs(1'b0, 2'd0, 3'b000));
        end
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, step_idx, gpio} !== e) begin
                n_err++;
                $display("FAIL once_trace T+%0d: got %b required %b", i, {busy, step_idx, gpio}, e);
            end
        end
    endtask

    task automatic test_loop_stop();
        logic [5:0] e;
        send_cmd(8'h81);
        for (int i = 1; i <= 30; i++) begin
            if ((i - 1) % 12 < 8) exp_q.push_back(obs(1'b1, 2'd0, 3'b001));
            else                  exp_q.push_back(obs(1'b1, 2'd1, 3'b101));
        end
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, step_idx, gpio} !== e) begin
                n_err++;
                $display("FAIL loop_trace T+%0d: got %b required %b", i, {busy, step_idx, gpio}, e);
            end
        end
        send_cmd(8'h83);
        exp_q.push_back(obs(1'b0, 2'd0, 3'b000));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({busy, step_idx, gpio} !== e) begin
            n_err++;
            $display("FAIL loop_stop: got %b required %b", {busy, step_idx, gpio}, e);
        end
    endtask

    task automatic test_long_step();
        logic [5:0] e;
        send_cmd(8'h80);
        send_cmd(8'h70);
        send_cmd(8'h11);
        send_cmd(8'h81);
        for (int i = 1; i <= 76; i++) begin
            if (i <= 64)      exp_q.push_back(obs(1'b1, 2'd0, 3'b111));
            else if (i <= 68) exp_q.push_back(obs(1'b1, 2'd1, 3'b001));
            else              exp_q.push_back(obs(1'b1, 2'd0, 3'b111));
        end
        for (int i = 1; i <= 76; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, step_idx, gpio} !== e) begin
                n_err++;
                $display("FAIL long_trace T+%0d: got %b required %b", i, {busy, step_idx, gpio}, e);
            end
        end
        send_cmd(8'h83);
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [5:0] e;
        send_cmd(8'h80);
        send_cmd(8'h11);
        send_cmd(8'h21);
        send_cmd(8'h31);
        send_cmd(8'h41);
        @(posedge clk);
        #1;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full_ok: got %b required 0", overflow);
        end
        send_cmd(8'h51);
        @(posedge clk);
        #1;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_fifth: got %b required 1", overflow);
        end
        send_cmd(8'h82);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(obs(1'b1, 2'(i / 4), 3'(i / 4 + 1)));
        end
        exp_q.push_back(obs(1'b0, 2'd0, 3'b000));
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if ({busy, step_idx, gpio} !== e) begin
                n_err++;
                $display("FAIL ovf_trace T+%0d: got %b required %b", i, {busy, step_idx, gpio}, e);
            end
        end
    endtask

    task automatic test_play_overflow_clear();
        send_cmd(8'h80);
        @(posedge clk);
        #1;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ovf: got %b required 0", overflow);
        end
        send_cmd(8'h11);
        send_cmd(8'h81);
        send_cmd(8'h22);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({overflow, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL play_ovf: got ovf,busy=%b required 11", {overflow, busy});
        end
        send_cmd(8'h80);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({overflow, busy, gpio} !== 5'b00_111) begin
            n_err++;
            $display("FAIL clear_in_play: got %b required 00111", {overflow, busy, gpio});
        end
        send_cmd(8'h82);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, gpio} !== 4'b0_111) begin
                n_err++;
                $display("FAIL start_empty T+%0d: got %b required 0111", i, {busy, gpio});
            end
        end
    endtask

    task automatic test_reset_mid();
        send_cmd(8'h13);
        send_cmd(8'h81);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, gpio} !== 4'b1_110) begin
            n_err++;
            $display("FAIL mid_pre_reset: got %b required 1110", {busy, gpio});
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, step_idx, gpio, cmd_ready, overflow} !== 8'b0_00_111_1_0) begin
            n_err++;
            $display("FAIL async_reset: got %b required 00011110", {busy, step_idx, gpio, cmd_ready, overflow});
        end
        @(negedge clk);
        resetn = 1'b1;
        send_cmd(8'h81);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, gpio} !== 4'b0_111) begin
                n_err++;
                $display("FAIL start_after_reset T+%0d: got %b required 0111", i, {busy, gpio});
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_toggle();
        test_once();
        test_loop_stop();
        test_long_step();
        test_overflow();
        test_play_overflow_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
